// File: rtl/kbd_pkg.sv
// Shared scan-code constants and encodings for the keyboard-to-cursor front end.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ISSUE,
        ST_HOLD
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INC,
        OP_DEC,
        OP_ROW,
        OP_UP,
        OP_DOWN
    } cur_op_t;

endpackage

// File: rtl/kbd_cursor_ctrl_cursor_pos.sv
// Text cursor register: linear cell address plus a column shadow so
// row-relative moves need no divider.
module cursor_pos
    import kbd_pkg::*;
#(
    parameter int COLS = 70,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        clrn,
    input  cur_op_t     op,
    output logic [11:0] count
);

    localparam logic [11:0] LAST     = 12'(COLS * ROWS - 1);
    localparam logic [11:0] LAST_ROW = 12'(COLS * ROWS - COLS);
    localparam logic [11:0] COLS_W   = 12'(COLS);
    localparam logic [11:0] COL_MAX  = 12'(COLS - 1);

    logic [11:0] col;
    logic [11:0] count_n;
    logic [11:0] col_n;
    logic [11:0] row_base;

    always_comb begin
        row_base = count - col;
        count_n  = count;
        col_n    = col;
        case (op)
            OP_INC: begin
                if (count == LAST) begin
                    count_n = '0;
                    col_n   = '0;
                end else begin
                    count_n = count + 12'd1;
                    col_n   = (col == COL_MAX) ? 12'd0 : col + 12'd1;
                end
            end
            OP_DEC: begin
                if (count != '0) begin
                    count_n = count - 12'd1;
                    col_n   = (col == '0) ? COL_MAX : col - 12'd1;
                end
            end
            OP_ROW: begin
                col_n   = '0;
                count_n = (row_base == LAST_ROW) ? 12'd0 : row_base + COLS_W;
            end
            OP_UP: begin
                if (count >= COLS_W)
                    count_n = count - COLS_W;
            end
            OP_DOWN: begin
                if (count < LAST_ROW)
                    count_n = count + COLS_W;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            count <= '0;
            col   <= '0;
        end else begin
            count <= count_n;
            col   <= col_n;
        end
    end

endmodule

// File: rtl/kbd_cursor_ctrl.sv
// PS/2 scan-code consumer: tracks modifiers and cursor, issues one
// held write request per printable make code.
module kbd_cursor_ctrl
    import kbd_pkg::*;
#(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int HOLD = 3
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ready,
    input  logic [7:0]  ps2_data,
    output logic        nextdata_n,
    output logic        wr_en,
    output logic [7:0]  scan_code,
    output logic        up,
    output logic [11:0] count,
    output logic        caps_led
);

    state_t      state, state_n;
    cur_op_t     op;
    logic [7:0]  byte_r;
    logic        brk, brk_n;
    logic        ext, ext_n;
    logic        shift_held, shift_n;
    logic        caps, caps_n;
    logic        caps_held, caps_held_n;
    logic        bksp_r, bksp_n;
    logic        do_wr;
    logic [7:0]  wr_code;
    logic [7:0]  hcnt;
    logic        is_shift;

    cursor_pos #(.COLS(COLS), .ROWS(ROWS)) u_pos (
        .clk   (clk),
        .clrn  (clrn),
        .op    (op),
        .count (count)
    );

    assign is_shift   = (byte_r == SC_LSHIFT) || (byte_r == SC_RSHIFT);
    assign wr_en      = (state == ST_ISSUE);
    assign nextdata_n = (state != ST_DECODE);
    assign caps_led   = caps;

    always_comb begin
        state_n     = state;
        op          = OP_NONE;
        brk_n       = brk;
        ext_n       = ext;
        shift_n     = shift_held;
        caps_n      = caps;
        caps_held_n = caps_held;
        bksp_n      = bksp_r;
        do_wr       = 1'b0;
        wr_code     = byte_r;
        case (state)
            ST_IDLE: begin
                if (ready)
                    state_n = ST_DECODE;
            end
            ST_DECODE: begin
                if (byte_r == SC_BREAK) begin
                    brk_n = 1'b1;
                end else if (byte_r == SC_EXT) begin
                    ext_n = 1'b1;
                end else if (brk) begin
                    if (is_shift)
                        shift_n = 1'b0;
                    else if (byte_r == SC_CAPS)
                        caps_held_n = 1'b0;
                    brk_n = 1'b0;
                    ext_n = 1'b0;
                end else if (ext) begin
                    case (byte_r)
                        SC_LEFT:  op = OP_DEC;
                        SC_RIGHT: op = OP_INC;
                        SC_UP:    op = OP_UP;
                        SC_DOWN:  op = OP_DOWN;
                        default:  ;
                    endcase
                    ext_n = 1'b0;
                end else if (is_shift) begin
                    shift_n = 1'b1;
                end else if (byte_r == SC_CAPS) begin
                    // typematic repeats arrive while held; only the first toggles
                    if (!caps_held)
                        caps_n = !caps;
                    caps_held_n = 1'b1;
                end else if (byte_r == SC_ENTER) begin
                    op = OP_ROW;
                end else if (byte_r == SC_BKSP) begin
                    if (count != '0) begin
                        op      = OP_DEC;
                        do_wr   = 1'b1;
                        wr_code = SC_SPACE;
                        bksp_n  = 1'b1;
                    end
                end else begin
                    do_wr  = 1'b1;
                    bksp_n = 1'b0;
                end
                state_n = do_wr ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                state_n = ST_HOLD;
            end
            ST_HOLD: begin
                if (hcnt == '0) begin
                    state_n = ST_IDLE;
                    if (!bksp_r)
                        op = OP_INC;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state      <= ST_IDLE;
            byte_r     <= '0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            shift_held <= 1'b0;
            caps       <= 1'b0;
            caps_held  <= 1'b0;
            bksp_r     <= 1'b0;
            scan_code  <= '0;
            up         <= 1'b0;
            hcnt       <= '0;
        end else begin
            state      <= state_n;
            brk        <= brk_n;
            ext        <= ext_n;
            shift_held <= shift_n;
            caps       <= caps_n;
            caps_held  <= caps_held_n;
            bksp_r     <= bksp_n;
            if (state == ST_IDLE && ready)
                byte_r <= ps2_data;
            if (do_wr) begin
                scan_code <= wr_code;
                up        <= shift_n ^ caps_n;
            end
            if (state == ST_ISSUE)
                hcnt <= 8'(HOLD - 1);
            else if (state == ST_HOLD)
                hcnt <= hcnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_kbd_cursor_ctrl.sv
// Directed bench for kbd_cursor_ctrl: byte table plus multi-cycle corner sequences.
module tb_kbd_cursor_ctrl;

    localparam int COLS = 70;
    localparam int ROWS = 30;
    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  ps2_data = 8'h00;
    logic        nextdata_n;
    logic        wr_en;
    logic [7:0]  scan_code;
    logic        up;
    logic [11:0] count;
    logic        caps_led;

    kbd_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .HOLD(HOLD)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ready      (ready),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .wr_en      (wr_en),
        .scan_code  (scan_code),
        .up         (up),
        .count      (count),
        .caps_led   (caps_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  sc;
        logic        up;
        logic [11:0] cnt;
    } wr_t;

    typedef struct {
        logic [7:0]  code;
        logic        exp_wr;
        logic [7:0]  exp_sc;
        logic        exp_up;
        logic [11:0] exp_wcnt;
        logic [11:0] exp_cnt;
        logic        exp_caps;
    } vec_t;

    wr_t  wq[$];
    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk)
        if (wr_en === 1'b1)
            wq.push_back('{scan_code, up, count});

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit popped = 1'b0;
        ready    = 1'b1;
        ps2_data = b;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (nextdata_n == 1'b0) begin
                popped = 1'b1;
                break;
            end
        end
        ready = 1'b0;
        if (!popped) begin
            errors++;
            checks++;
            $display("FAIL pop_timeout: no pop for byte %0h", b);
        end
        repeat (7) tick();
    endtask

    task automatic move(input logic [7:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            send(8'hE0);
            send(code);
        end
    endtask

    task automatic do_reset();
        clrn  = 1'b0;
        ready = 1'b0;
        repeat (2) tick();
        clrn = 1'b1;
        tick();
        wq.delete();
    endtask

    task automatic add(input logic [7:0] code, input logic w,
                       input logic [7:0] sc, input logic u,
                       input logic [11:0] wc, input logic [11:0] c,
                       input logic cp);
        vt.push_back('{code, w, sc, u, wc, c, cp});
    endtask

    task automatic issue_and_wait(output bit seen);
        seen     = 1'b0;
        ready    = 1'b1;
        ps2_data = 8'h1C;
        tick();
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (wr_en) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL wr_timeout: no wr_en seen");
        end
    endtask

    initial begin
        bit          seen;
        logic [11:0] c0;
        logic [7:0]  s0;
        bit          bad;

        add(8'h1C, 1, 8'h1C, 0, 0, 1, 0);
        add(8'hF0, 0, 0, 0, 0, 1, 0);
        add(8'h1C, 0, 0, 0, 0, 1, 0);
        add(8'h12, 0, 0, 0, 0, 1, 0);
        add(8'h1C, 1, 8'h1C, 1, 1, 2, 0);
        add(8'hF0, 0, 0, 0, 0, 2, 0);
        add(8'h12, 0, 0, 0, 0, 2, 0);
        add(8'h1C, 1, 8'h1C, 0, 2, 3, 0);
        add(8'h58, 0, 0, 0, 0, 3, 1);
        add(8'h58, 0, 0, 0, 0, 3, 1);
        add(8'hF0, 0, 0, 0, 0, 3, 1);
        add(8'h58, 0, 0, 0, 0, 3, 1);
        add(8'h1C, 1, 8'h1C, 1, 3, 4, 1);
        add(8'h59, 0, 0, 0, 0, 4, 1);
        add(8'h1C, 1, 8'h1C, 0, 4, 5, 1);
        add(8'hF0, 0, 0, 0, 0, 5, 1);
        add(8'h59, 0, 0, 0, 0, 5, 1);
        add(8'h58, 0, 0, 0, 0, 5, 0);
        add(8'hF0, 0, 0, 0, 0, 5, 0);
        add(8'h58, 0, 0, 0, 0, 5, 0);
        add(8'h1C, 1, 8'h1C, 0, 5, 6, 0);
        add(8'h66, 1, 8'h29, 0, 5, 5, 0);
        add(8'h5A, 0, 0, 0, 0, 70, 0);
        add(8'hE0, 0, 0, 0, 0, 70, 0);
        add(8'h6B, 0, 0, 0, 0, 69, 0);
        add(8'h1C, 1, 8'h1C, 0, 69, 70, 0);
        add(8'hE0, 0, 0, 0, 0, 70, 0);
        add(8'h75, 0, 0, 0, 0, 0, 0);
        add(8'hE0, 0, 0, 0, 0, 0, 0);
        add(8'h75, 0, 0, 0, 0, 0, 0);
        add(8'hE0, 0, 0, 0, 0, 0, 0);
        add(8'h6B, 0, 0, 0, 0, 0, 0);
        add(8'h66, 0, 0, 0, 0, 0, 0);
        add(8'hE0, 0, 0, 0, 0, 0, 0);
        add(8'hF0, 0, 0, 0, 0, 0, 0);
        add(8'h6B, 0, 0, 0, 0, 0, 0);
        add(8'h1C, 1, 8'h1C, 0, 0, 1, 0);
        add(8'hE0, 0, 0, 0, 0, 1, 0);
        add(8'h72, 0, 0, 0, 0, 71, 0);
        add(8'h66, 1, 8'h29, 0, 70, 70, 0);

        repeat (3) tick();
        clrn = 1'b1;
        chk("rst_count", 32'(count), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_nextdata_n", 32'(nextdata_n), 1);
        chk("rst_caps", 32'(caps_led), 0);
        chk("rst_scan_code", 32'(scan_code), 0);
        tick();

        foreach (vt[i]) begin
            wq.delete();
            send(vt[i].code);
            chk($sformatf("v%0d_nwr", i), 32'(wq.size()), 32'(vt[i].exp_wr));
            if (vt[i].exp_wr && wq.size() == 1) begin
                chk($sformatf("v%0d_sc", i), 32'(wq[0].sc), 32'(vt[i].exp_sc));
                chk($sformatf("v%0d_up", i), 32'(wq[0].up), 32'(vt[i].exp_up));
                chk($sformatf("v%0d_wcnt", i), 32'(wq[0].cnt), 32'(vt[i].exp_wcnt));
            end
            chk($sformatf("v%0d_cnt", i), 32'(count), 32'(vt[i].exp_cnt));
            chk($sformatf("v%0d_caps", i), 32'(caps_led), 32'(vt[i].exp_caps));
        end

        do_reset();
        move(8'h72, 29);
        chk("down_to_last_row", 32'(count), 2030);
        move(8'h72, 1);
        chk("down_sat", 32'(count), 2030);
        move(8'h74, 69);
        chk("at_2099", 32'(count), 2099);
        wq.delete();
        send(8'h1C);
        chk("last_nwr", 32'(wq.size()), 1);
        if (wq.size() == 1)
            chk("last_wcnt", 32'(wq[0].cnt), 2099);
        chk("last_wrap", 32'(count), 0);

        move(8'h72, 29);
        move(8'h74, 60);
        chk("at_2090", 32'(count), 2090);
        wq.delete();
        send(8'h5A);
        chk("enter_wrap", 32'(count), 0);
        chk("enter_nwr", 32'(wq.size()), 0);

        issue_and_wait(seen);
        if (seen) begin
            c0  = count;
            s0  = scan_code;
            bad = 1'b0;
            for (int i = 0; i < HOLD; i++) begin
                tick();
                if (count !== c0 || scan_code !== s0 || wr_en !== 1'b0)
                    bad = 1'b1;
            end
            chk("hold_stable", 32'(bad), 0);
            tick();
            chk("hold_advance", 32'(count), 32'(c0) + 1);
        end

        do_reset();
        send(8'h58);
        move(8'h74, 10);
        chk("pre_rst_count", 32'(count), 10);
        chk("pre_rst_caps", 32'(caps_led), 1);
        issue_and_wait(seen);
        tick();
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_caps", 32'(caps_led), 0);
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_nextdata_n", 32'(nextdata_n), 1);
        wq.delete();
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (nextdata_n !== 1'b1 || wr_en !== 1'b0 || count !== 12'd0)
                bad = 1'b1;
        end
        chk("post_rst_quiet", 32'(bad), 0);
        send(8'h1C);
        chk("post_rst_nwr", 32'(wq.size()), 1);
        if (wq.size() == 1) begin
            chk("post_rst_wcnt", 32'(wq[0].cnt), 0);
            chk("post_rst_up", 32'(wq[0].up), 0);
        end
        chk("post_rst_count", 32'(count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
